alu_seq: RTL

- Parametrised, registered successor to the combinational accumulator ALU.
- Same operation encoding, plus a start/busy/done handshake, a multi-cycle signed shift-add multiplier, and registered status flags (zero, negative, overflow).
- Sits between accumulator and data-bus in each processor core; the core control unit issues one operation at a time and waits for done.

---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq : registered accumulator ALU with start/busy/done handshake,     |
// |           WIDTH-cycle signed shift-add multiplier and status flags.      |
// | Option  : ALU_SATURATE_EN clamps overflowing results to the signed range.|
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       selectOp,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             ovfFlag
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int MSB   = WIDTH - 1;

  localparam logic [2:0] c_OP_PASS = 3'd1;
  localparam logic [2:0] c_OP_ADD  = 3'd2;
  localparam logic [2:0] c_OP_SUB  = 3'd3;
  localparam logic [2:0] c_OP_MUL  = 3'd4;
  localparam logic [2:0] c_OP_INC  = 3'd5;

  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   c_XONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0]    c_PONE = {{(PW-1){1'b0}}, 1'b1};

  if (WIDTH < 4) begin : g_width_check
    $error("alu_seq: WIDTH must be >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_sign;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH:0]   r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_a_mag;
  logic [WIDTH:0]   w_b_mag;
  logic [PW-1:0]    w_prod;
  logic [WIDTH:0]   w_prod_top;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_out;

  // One extra bit so that |-2^(WIDTH-1)| is representable.
  assign w_a_ext = {a[MSB], a};
  assign w_b_ext = {b[MSB], b};
  assign w_a_mag = a[MSB] ? (~w_a_ext + c_XONE) : w_a_ext;
  assign w_b_mag = b[MSB] ? (~w_b_ext + c_XONE) : w_b_ext;

  assign w_prod     = r_sign ? (~r_acc + c_PONE) : r_acc;
  assign w_prod_top = w_prod[PW-1:WIDTH-1];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      c_OP_PASS: w_res = r_b;
      c_OP_ADD: begin
        w_res = r_a + r_b;
        w_ovf = (r_a[MSB] == r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      c_OP_SUB: begin
        w_res = r_a - r_b;
        w_ovf = (r_a[MSB] != r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      c_OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        // Fits the result range only if the top WIDTH+1 bits are a sign run.
        w_ovf = !((&w_prod_top) || !(|w_prod_top));
      end
      c_OP_INC: begin
        w_res = r_a + c_ONE;
        w_ovf = (r_a == c_MAX);
      end
      default: w_res = '0;
    endcase
  end

`ifdef ALU_SATURATE_EN
  logic w_true_neg;

  // Overflow only occurs on add/sub (sign of a), inc (positive) and mul.
  always_comb begin
    w_true_neg = 1'b0;
    if (r_op == c_OP_MUL) begin
      w_true_neg = r_sign;
    end else if (r_op != c_OP_INC) begin
      w_true_neg = r_a[MSB];
    end
  end

  assign w_out = w_ovf ? (w_true_neg ? ~c_MAX : c_MAX) : w_res;
`else
  assign w_out = w_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      dataOut  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      zeroFlag <= 1'b1;
      negFlag  <= 1'b0;
      ovfFlag  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= selectOp;
            if (selectOp == c_OP_MUL) begin
              r_sign   <= a[MSB] ^ b[MSB];
              r_mcand  <= {{(WIDTH-1){1'b0}}, w_a_mag};
              r_mplier <= w_b_mag;
              r_acc    <= '0;
              r_cnt    <= CNT_W'(WIDTH);
              busy     <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIN;
          end
        end
        S_EXEC, S_FIN: begin
          dataOut  <= w_out;
          zeroFlag <= (w_out == '0);
          negFlag  <= w_out[MSB];
          ovfFlag  <= w_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
